// File: rtl/mem_wb_sram_stage.sv
// MEM/WB stage: multi-cycle SRAM access FSM that freezes the upstream pipeline, plus the MEM/WB register.
// Define SRAM_WRITE_BUFFER_EN to add a one-entry posted-write buffer (extra FSM state WBUF).
module mem_wb_sram_stage #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    input  logic [3:0]  Dest_in,
    output logic        freeze,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_WB,
    output logic [17:0] SRAM_ADDR,
    output logic [31:0] SRAM_DQ_out,
    input  logic [31:0] SRAM_DQ_in,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
`ifdef SRAM_WRITE_BUFFER_EN
    localparam logic [1:0] S_WBUF   = 2'd3;
`endif
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] rdata;
    logic        is_wr;
    logic        mem_op;
    logic [17:0] word_addr;

    assign mem_op    = MEM_R_EN | MEM_W_EN;
    assign word_addr = 18'((ALU_Res - 32'd1024) >> 2);

`ifdef SRAM_WRITE_BUFFER_EN
    logic        wbuf_vld;
    logic [17:0] wbuf_addr;
    logic [31:0] wbuf_data;
    logic        frz_q;
    logic        post_wr;

    // A store that was held behind a drain goes through the normal ACCESS path, not the buffer.
    assign post_wr   = (state == S_IDLE) && MEM_W_EN && !MEM_R_EN && !wbuf_vld && !frz_q;
    assign freeze    = mem_op && (state != S_DONE) && !post_wr;
    assign SRAM_WE_N = !(((state == S_ACCESS) && is_wr) || (state == S_WBUF));
    assign SRAM_ADDR = (state == S_WBUF) ? wbuf_addr : word_addr;
    assign SRAM_DQ_out = (state == S_WBUF) ? wbuf_data : Val_Rm;
`else
    assign freeze      = mem_op && (state != S_DONE);
    assign SRAM_WE_N   = !((state == S_ACCESS) && is_wr);
    assign SRAM_ADDR   = word_addr;
    assign SRAM_DQ_out = Val_Rm;
`endif
    assign SRAM_OE_N = !((state == S_ACCESS) && !is_wr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            rdata <= '0;
            is_wr <= 1'b0;
`ifdef SRAM_WRITE_BUFFER_EN
            wbuf_vld  <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
            frz_q     <= 1'b0;
`endif
        end else begin
`ifdef SRAM_WRITE_BUFFER_EN
            frz_q <= freeze;
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
`ifdef SRAM_WRITE_BUFFER_EN
                    if (post_wr) begin
                        state     <= S_WBUF;
                        wbuf_vld  <= 1'b1;
                        wbuf_addr <= word_addr;
                        wbuf_data <= Val_Rm;
                    end else
`endif
                    if (mem_op) begin
                        state <= S_ACCESS;
                        // Loads win if both enables are raised, keeping the strobes exclusive.
                        is_wr <= MEM_W_EN & ~MEM_R_EN;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        if (!is_wr) rdata <= SRAM_DQ_in;
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
`ifdef SRAM_WRITE_BUFFER_EN
                S_WBUF: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        wbuf_vld <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register: a frozen cycle inserts a bubble and holds the payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_WB   <= '0;
        end else if (freeze) begin
            writeBackEn <= 1'b0;
        end else begin
            writeBackEn <= WB_EN_in;
            Dest_wb     <= Dest_in;
            Result_WB   <= MEM_R_EN ? rdata : ALU_Res;
        end
    end

endmodule

// File: doc/mem_wb_sram_stage.md
MEM_WB_SRAM_STAGE -- requirements
Module: mem_wb_sram_stage

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, meaning SRAM access cycles per transfer (legal 1..15).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- WB_EN_in  in  1  EXE-stage writeback enable.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- ALU_Res  in  32  byte address (memory ops) or result (others).
- Val_Rm  in  32  store data.
- Dest_in  in  4  destination register.
- freeze  out  1  stall to IF/ID/EXE and their pipeline registers.
- writeBackEn  out  1  register-file write enable to ID.
- Dest_wb  out  4  register-file write index to ID.
- Result_WB  out  32  register-file write data to ID.
- SRAM_ADDR  out  18  SRAM word address.
- SRAM_DQ_out  out  32  SRAM write data.
- SRAM_DQ_in  in  32  SRAM read data.
- SRAM_WE_N  out  1  SRAM write strobe, active-low.
- SRAM_OE_N  out  1  SRAM output enable, active-low.

Function
REQ-003 SHALL compute SRAM_ADDR = ((ALU_Res - 1024) >> 2)[17:0]; SRAM_DQ_out = Val_Rm of the access in progress.
REQ-004 SHALL implement FSM IDLE, ACCESS, DONE; 4-bit cycle counter.
REQ-005 IDLE: on MEM_R_EN|MEM_W_EN SHALL go to ACCESS with counter = 0; else stay.
REQ-006 ACCESS: SRAM_WE_N = 0 (store) or SRAM_OE_N = 0 (load); counter increments each cycle; at counter == WAIT_CYCLES-1 SHALL capture SRAM_DQ_in into rdata (loads) and go to DONE.
REQ-007 DONE: strobes high; SHALL return to IDLE next cycle unconditionally.
REQ-008 freeze SHALL be combinational: (MEM_R_EN|MEM_W_EN) & (state != DONE); a memory op thus freezes exactly WAIT_CYCLES+1 cycles.
REQ-009 Non-memory ops SHALL never assert freeze and SHALL reach the writeback outputs with 1-cycle latency.
REQ-010 MEM/WB register: when freeze == 0, on clk SHALL load writeBackEn <= WB_EN_in, Dest_wb <= Dest_in, Result_WB <= MEM_R_EN ? rdata : ALU_Res.
REQ-011 When freeze == 1, SHALL load writeBackEn <= 0 (bubble); Dest_wb, Result_WB hold.
REQ-012 Back-to-back memory ops: the op following DONE SHALL start from IDLE with no extra idle cycle beyond REQ-007.
REQ-013 SRAM_WE_N and SRAM_OE_N SHALL never be low simultaneously; both high outside ACCESS.

Reset
REQ-014 rst low SHALL immediately force state IDLE, counter 0, rdata 0, writeBackEn 0, Dest_wb 0, Result_WB 0, SRAM_WE_N 1, SRAM_OE_N 1, including mid-ACCESS.
REQ-015 After rst release, an already-asserted request SHALL start from IDLE; freeze follows REQ-008.

Configuration
REQ-016 Macro SRAM_WRITE_BUFFER_EN SHALL, when defined, add a one-entry posted-write buffer (address, data, valid) and FSM state WBUF.
REQ-017 With macro: store in IDLE with buffer empty SHALL be latched into the buffer with freeze = 0; FSM runs WBUF for WAIT_CYCLES cycles with SRAM_WE_N = 0, then clears valid and returns to IDLE.
REQ-018 With macro: any memory op arriving while buffer valid SHALL freeze until drain completes, then proceed per REQ-005..REQ-008; non-memory ops SHALL proceed unfrozen during drain.
REQ-019 Without macro: no buffer, no WBUF; stores stall per REQ-008.

Verification (WAIT_CYCLES = 3)
REQ-020 Non-mem op ALU_Res=0x55, Dest_in=4, WB_EN_in=1 -> next edge writeBackEn=1, Dest_wb=4, Result_WB=0x55; freeze stays 0.
REQ-021 Store ALU_Res=1028, Val_Rm=0xDEADBEEF -> SRAM_ADDR=1, SRAM_WE_N low 3 cycles, freeze high 4 cycles, writeBackEn 0.
REQ-022 Then load ALU_Res=1028, Dest_in=7 -> SRAM_OE_N low 3 cycles, freeze high 4 cycles, then writeBackEn=1, Dest_wb=7, Result_WB=0xDEADBEEF.
REQ-023 rst low during 2nd ACCESS cycle -> same cycle SRAM_WE_N=SRAM_OE_N=1, all outputs 0; after release, pending load completes with correct data.
REQ-024 With SRAM_WRITE_BUFFER_EN: store to 1032, then load from 1032 -> store freeze 0; load freeze high through drain plus 4 cycles; Result_WB equals stored value.
